vigenere_stream_cipher: RTL

Streaming Vigenere encrypt/decrypt engine. It is the parametrised successor to the fixed 10-character Vigenere blocks.
- Key length is configurable up to KEY_LEN characters, loaded one character at a time.
- Mode (encrypt or decrypt) is selected per character.
- Data moves through valid/ready handshakes with one register stage.
- Sits between a character source (UART/ROM) and a sink in the cipher datapath.

---
 rtl/vigenere_stream_cipher.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/vigenere_stream_cipher.sv
// vigenere_stream_cipher: streaming Vigenere encrypt/decrypt engine with a
// runtime-loadable key of up to KEY_LEN uppercase letters and a single
// valid/ready output register stage.
// Optional build macro VIGENERE_LOWERCASE_EN: when defined, 'a'..'z' are
// ciphered (staying lowercase) and advance the key index; otherwise they
// pass through like any other non-letter.
module vigenere_stream_cipher #(
  parameter int KEY_LEN = 16,
  parameter int IDX_W   = $clog2(KEY_LEN + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       keyChar,
  input  logic             keyWrite,
  input  logic             keyClear,
  input  logic             decrypt,
  input  logic [7:0]       inChar,
  input  logic             inValid,
  output logic             inReady,
  output logic [7:0]       outChar,
  output logic             outValid,
  input  logic             outReady,
  output logic [IDX_W-1:0] keyLen,
  output logic             keyError
);

  localparam int               ADDR_W  = $clog2(KEY_LEN);
  localparam logic [IDX_W-1:0] KEY_MAX = IDX_W'(KEY_LEN);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic {EMPTY, RUN} state_t;

  // Key storage holds the shift amount (0..25) rather than the raw letter.
  logic [4:0] key_mem [KEY_LEN];

  state_t           state_q, state_d;
  logic [IDX_W-1:0] key_len_q, key_len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       out_char_q, out_char_d;
  logic             out_valid_q, out_valid_d;
  logic             key_error_q, key_error_d;

  logic             key_char_ok;
  logic             key_wr_ok;
  logic             in_ready_c;
  logic             accept;
  logic [4:0]       key_sel;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
`ifdef VIGENERE_LOWERCASE_EN
    return (c >= 8'h61) && (c <= 8'h7A);
`else
    return (c == 8'h00) && (c != 8'h00);
`endif
  endfunction

  function automatic logic is_letter(input logic [7:0] c);
    return is_upper(c) || is_lower(c);
  endfunction

  // Letters occupy 0x41..0x5A / 0x61..0x7A, so bits [7:6] are always 2'b01
  // and the alphabet position lives entirely in the low six bits.
  function automatic logic [7:0] cipher_char(input logic [7:0] c,
                                             input logic [4:0] s,
                                             input logic       dec);
    logic [5:0] base;
    logic [5:0] p;
    logic [5:0] sum;
    base = is_lower(c) ? 6'h21 : 6'h01;
    p    = c[5:0] - base;
    if (dec) sum = p + 6'd26 - {1'b0, s};
    else     sum = p + {1'b0, s};
    if (sum >= 6'd26) sum = sum - 6'd26;
    return is_letter(c) ? {2'b01, base + sum} : c;
  endfunction

  // Handshake qualification, key write acceptance and the next-state logic.
  always_comb begin
    key_char_ok = is_upper(keyChar);
    key_wr_ok   = keyWrite && key_char_ok && (key_len_q < KEY_MAX) && !out_valid_q;
    in_ready_c  = (state_q == RUN) && !keyWrite && (!out_valid_q || outReady);
    accept      = inValid && in_ready_c;
    key_sel     = key_mem[idx_q[ADDR_W-1:0]];

    state_d     = state_q;
    key_len_d   = key_len_q;
    idx_d       = idx_q;
    out_char_d  = out_char_q;
    out_valid_d = out_valid_q;
    key_error_d = key_error_q;

    if (keyClear) begin
      state_d     = EMPTY;
      key_len_d   = '0;
      idx_d       = '0;
      out_valid_d = 1'b0;
      key_error_d = 1'b0;
    end else begin
      if (keyWrite) begin
        if (key_wr_ok) begin
          state_d   = RUN;
          key_len_d = key_len_q + IDX_ONE;
        end else begin
          key_error_d = 1'b1;
        end
      end
      if (accept) begin
        out_char_d  = cipher_char(inChar, key_sel, decrypt);
        out_valid_d = 1'b1;
        if (is_letter(inChar)) begin
          idx_d = (idx_q == key_len_q - IDX_ONE) ? '0 : idx_q + IDX_ONE;
        end
      end else if (outReady) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Control and output registers, asynchronously reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      key_len_q   <= '0;
      idx_q       <= '0;
      out_char_q  <= '0;
      out_valid_q <= 1'b0;
      key_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_len_q   <= key_len_d;
      idx_q       <= idx_d;
      out_char_q  <= out_char_d;
      out_valid_q <= out_valid_d;
      key_error_q <= key_error_d;
    end
  end

  // Key storage write; contents are don't-care after reset or clear.
  always_ff @(posedge clock) begin
    if (!keyClear && key_wr_ok) begin
      key_mem[key_len_q[ADDR_W-1:0]] <= keyChar[4:0] - 5'd1;
    end
  end

  assign inReady  = in_ready_c;
  assign outChar  = out_char_q;
  assign outValid = out_valid_q;
  assign keyLen   = key_len_q;
  assign keyError = key_error_q;

endmodule
